alu_seq: RTL and testbench

//  Parametrised, registered successor to the combinational ALU. It adds a WIDTH

---
 rtl/alu_seq.sv | 194 +++++++++++++++++++
 tb/tb_alu_seq.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered ALU with valid/ready handshake and multi-cycle shift-add multiplier
// One operation in flight: IDLE accepts, BUSY iterates MUL, DONE holds the result until taken.
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             slt,
  output logic             overflow,
  output logic             err
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam logic [3:0] OP_SLL = 4'b1001;
  localparam logic [3:0] OP_SRL = 4'b1010;

  localparam logic [SHW:0] MUL_STEPS = (SHW+1)'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 carry_q, carry_d;
  logic                 zero_q, zero_d;
  logic                 slt_q, slt_d;
  logic                 overflow_q, overflow_d;
  logic                 err_q, err_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [SHW:0]         cnt_q, cnt_d;

  logic [WIDTH:0]       add_sum, sub_sum;
  logic                 add_ovf, sub_ovf, sub_lt;
  logic [WIDTH-1:0]     alu_res;
  logic                 alu_carry, alu_slt, alu_ovf, alu_err;
  logic [2*WIDTH-1:0]   acc_step;

  // Single-cycle datapath, evaluated directly on the incoming operands.
  always_comb begin
    add_sum   = {1'b0, a} + {1'b0, b};
    sub_sum   = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    add_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (add_sum[WIDTH-1] != a[WIDTH-1]);
    sub_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_sum[WIDTH-1] != a[WIDTH-1]);
    sub_lt    = sub_sum[WIDTH-1] ^ sub_ovf;
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_slt   = 1'b0;
    alu_ovf   = 1'b0;
    alu_err   = 1'b0;
    case (op)
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_NOR: alu_res = ~(a | b);
      OP_ADD: begin
        alu_res   = add_sum[WIDTH-1:0];
        alu_carry = add_sum[WIDTH];
        alu_ovf   = add_ovf;
      end
      OP_SUB: begin
        alu_res   = sub_sum[WIDTH-1:0];
        alu_carry = sub_sum[WIDTH];
        alu_ovf   = sub_ovf;
        alu_slt   = sub_lt;
      end
      OP_SLT: begin
        alu_res   = {{(WIDTH-1){1'b0}}, sub_lt};
        alu_carry = sub_sum[WIDTH];
        alu_slt   = sub_lt;
      end
      OP_SLL: alu_res = a << b[SHW-1:0];
      OP_SRL: alu_res = a >> b[SHW-1:0];
      OP_MUL: alu_res = '0;
      default: alu_err = 1'b1;
    endcase
  end

  assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    carry_d    = carry_q;
    zero_d     = zero_q;
    slt_d      = slt_q;
    overflow_d = overflow_q;
    err_d      = err_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    cnt_d      = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (op == OP_MUL) begin
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            cnt_d    = '0;
            state_d  = S_BUSY;
          end else begin
            result_d   = alu_res;
            carry_d    = alu_carry;
            zero_d     = (alu_res == '0);
            slt_d      = alu_slt;
            overflow_d = alu_ovf;
            err_d      = alu_err;
            state_d    = S_DONE;
          end
        end
      end
      S_BUSY: begin
        // WIDTH partial-product steps, then one edge to publish the product.
        if (cnt_q == MUL_STEPS) begin
          result_d   = acc_q[WIDTH-1:0];
          carry_d    = |acc_q[2*WIDTH-1:WIDTH];
          zero_d     = (acc_q[WIDTH-1:0] == '0);
          slt_d      = 1'b0;
          overflow_d = 1'b0;
          err_d      = 1'b0;
          state_d    = S_DONE;
        end else begin
          acc_d    = acc_step;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      result_q   <= '0;
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
      slt_q      <= 1'b0;
      overflow_q <= 1'b0;
      err_q      <= 1'b0;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      result_q   <= result_d;
      carry_q    <= carry_d;
      zero_q     <= zero_d;
      slt_q      <= slt_d;
      overflow_q <= overflow_d;
      err_q      <= err_d;
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      cnt_q      <= cnt_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign slt       = slt_q;
  assign overflow  = overflow_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq with an arithmetic reference model
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] op = 4'h0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] result;
  logic       carry, zero, slt, overflow, err;

  int vectors = 0;
  int miscompares = 0;

  alu_seq #(.WIDTH(8), .SHW(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry(carry), .zero(zero), .slt(slt),
    .overflow(overflow), .err(err)
  );

  always #5 clk = ~clk;

  // Returns {result, carry, zero, slt, overflow, err} from plain integer arithmetic.
  function automatic logic [12:0] model(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
    int ux = x;
    int uy = y;
    int sx = $signed(x);
    int sy = $signed(y);
    int full;
    logic [7:0] r = 8'h00;
    logic c = 1'b0, s = 1'b0, v = 1'b0, e = 1'b0;
    case (o)
      4'h0: r = x & y;
      4'h1: r = x | y;
      4'hC: r = ~(x | y);
      4'h2: begin full = ux + uy; r = full[7:0]; c = (full > 255); v = (sx + sy > 127) || (sx + sy < -128); end
      4'h6: begin r = 8'(ux - uy); c = (ux >= uy); v = (sx - sy > 127) || (sx - sy < -128); s = (sx < sy); end
      4'h7: begin s = (sx < sy); r = {7'b0, s}; c = (ux >= uy); end
      4'h8: begin full = ux * uy; r = full[7:0]; c = (full > 255); end
      4'h9: r = 8'(ux << (uy % 8));
      4'hA: r = 8'(ux >> (uy % 8));
      default: e = 1'b1;
    endcase
    return {r, c, (r == 8'h00), s, v, e};
  endfunction

  // Presents one op from IDLE; lat = edges after the accept edge until out_valid (-1 on timeout).
  task automatic issue(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y, output int lat);
    @(negedge clk);
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic take_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({result, carry, zero, slt, overflow, err, out_valid, in_ready} !== {8'h00, 6'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL reset_outputs: got r=%h c%b z%b s%b v%b e%b ov%b ir%b, want all 0 with in_ready=1",
               result, carry, zero, slt, overflow, err, out_valid, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add();
    int lat;
    issue(4'h2, 8'hFF, 8'h01, lat);
    vectors++;
    if (lat !== 0) begin
      miscompares++; $display("FAIL add_latency: got %0d edges after accept, want 0", lat);
    end
    vectors++;
    if ({result, carry, zero, overflow} !== {8'h00, 1'b1, 1'b1, 1'b0}) begin
      miscompares++; $display("FAIL add_ff_01: got r=%h c%b z%b v%b, want r=00 c1 z1 v0", result, carry, zero, overflow);
    end
    take_result();
  endtask

  task automatic test_sub_slt();
    int lat;
    issue(4'h6, 8'h80, 8'h01, lat);
    vectors++;
    if ({result, overflow, slt, carry} !== {8'h7F, 1'b1, 1'b1, 1'b1}) begin
      miscompares++; $display("FAIL sub_80_01: got r=%h v%b s%b c%b, want r=7f v1 s1 c1", result, overflow, slt, carry);
    end
    take_result();
    issue(4'h7, 8'h03, 8'hFD, lat);
    vectors++;
    if ({result, slt} !== {8'h00, 1'b0}) begin
      miscompares++; $display("FAIL slt_03_fd: got r=%h s%b, want r=00 s0", result, slt);
    end
    take_result();
  endtask

  task automatic test_mul();
    int lat;
    issue(4'h8, 8'h0D, 8'h0B, lat);
    vectors++;
    if (lat !== 9) begin
      miscompares++; $display("FAIL mul_latency: got %0d edges after accept, want 9", lat);
    end
    vectors++;
    if ({result, carry} !== {8'h8F, 1'b0}) begin
      miscompares++; $display("FAIL mul_0d_0b: got r=%h c%b, want r=8f c0", result, carry);
    end
    take_result();
    issue(4'h8, 8'hFF, 8'h02, lat);
    vectors++;
    if ({result, carry} !== {8'hFE, 1'b1}) begin
      miscompares++; $display("FAIL mul_ff_02: got r=%h c%b, want r=fe c1", result, carry);
    end
    take_result();
  endtask

  task automatic test_backpressure();
    int lat;
    issue(4'hA, 8'hF0, 8'h04, lat);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      op = 4'h2; a = 8'h11; b = 8'h22; in_valid = 1'b1;
      @(posedge clk); #1;
      vectors++;
      if ({result, out_valid, in_ready} !== {8'h0F, 1'b1, 1'b0}) begin
        miscompares++;
        $display("FAIL backpressure_hold[%0d]: got r=%h ov%b ir%b, want r=0f ov1 ir0", i, result, out_valid, in_ready);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    take_result();
    vectors++;
    if ({out_valid, in_ready} !== 2'b01) begin
      miscompares++; $display("FAIL backpressure_release: got ov%b ir%b, want ov0 ir1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_mul();
    int lat;
    @(negedge clk);
    op = 4'h8; a = 8'hFF; b = 8'hFF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    vectors++;
    if ({result, carry, zero, slt, overflow, err, out_valid, in_ready} !== {8'h00, 6'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL reset_mid_mul: got r=%h c%b z%b s%b v%b e%b ov%b ir%b, want all 0 with in_ready=1",
               result, carry, zero, slt, overflow, err, out_valid, in_ready);
    end
    repeat (12) @(posedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_discards_mul: got out_valid=%b, want 0", out_valid);
    end
    issue(4'h2, 8'h02, 8'h03, lat);
    vectors++;
    if ({lat == 0, result} !== {1'b1, 8'h05}) begin
      miscompares++; $display("FAIL add_after_reset: got r=%h lat=%0d, want r=05 lat=0", result, lat);
    end
    take_result();
  endtask

  task automatic test_illegal();
    int lat;
    issue(4'hF, 8'h5A, 8'hA5, lat);
    vectors++;
    if ({err, result, zero, carry, slt, overflow} !== {1'b1, 8'h00, 1'b1, 3'b000}) begin
      miscompares++; $display("FAIL illegal_op: got e%b r=%h z%b c%b s%b v%b, want e1 r=00 z1 others 0",
                              err, result, zero, carry, slt, overflow);
    end
    take_result();
    issue(4'h1, 8'h0A, 8'h05, lat);
    vectors++;
    if ({err, result} !== {1'b0, 8'h0F}) begin
      miscompares++; $display("FAIL or_after_illegal: got e%b r=%h, want e0 r=0f", err, result);
    end
    take_result();
  endtask

  task automatic test_random();
    logic [3:0] ops[10] = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'hC, 4'h8, 4'h9, 4'hA, 4'hF};
    for (int n = 0; n < 150; n++) begin
      logic [3:0]  o = ops[$urandom_range(9)];
      logic [7:0]  x = 8'($urandom);
      logic [7:0]  y = 8'($urandom);
      logic [12:0] exp = model(o, x, y);
      int          lat;
      int          want_lat = (o == 4'h8) ? 9 : 0;
      if ($urandom_range(9) == 0) o = 4'($urandom);
      exp = model(o, x, y);
      want_lat = (o == 4'h8) ? 9 : 0;
      issue(o, x, y, lat);
      vectors++;
      if (lat !== want_lat) begin
        miscompares++; $display("FAIL rand_latency op=%h: got %0d, want %0d", o, lat, want_lat);
      end
      repeat ($urandom_range(2)) @(posedge clk);
      #1;
      vectors++;
      if ({result, carry, zero, slt, overflow, err} !== exp) begin
        miscompares++;
        $display("FAIL rand_result op=%h a=%h b=%h: got r=%h c%b z%b s%b v%b e%b, want r=%h c%b z%b s%b v%b e%b",
                 o, x, y, result, carry, zero, slt, overflow, err,
                 exp[12:5], exp[4], exp[3], exp[2], exp[1], exp[0]);
      end
      take_result();
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_slt();
    test_mul();
    test_backpressure();
    test_reset_mid_mul();
    test_illegal();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
